pipelined_booth_multiplier: RTL and testbench

- Parametrised, fully pipelined WIDTH x WIDTH integer multiplier.
- Datapath: radix-4 Booth partial-product generation, then a Wallace/CSA tree, then a final CLA.
- Three registered stages with valid/ready flow control and per-operation signed/unsigned selection.
- Sits between the ALU issue logic and writeback; accepts one operation per cycle and returns the full 2*WIDTH product, a WIDTH-bit truncated result and an overflow flag.

---
 rtl/pipelined_booth_multiplier.sv | 173 +++++++++++++++++
 tb/tb_pipelined_booth_multiplier.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_booth_multiplier.sv
// Radix-4 Booth multiplier (Booth PPs -> CSA tree -> prefix CLA), three register stages, 3-cycle latency.
// Bubble-collapsing valid/ready: a stage advances when its successor is empty or advancing; out_ready low stalls the pipe.
module pipelined_booth_multiplier #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplicand,
  input  logic [WIDTH-1:0]   in_multiplier,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_overflow,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NPP = WIDTH / 2 + 1;
  localparam int PPW = WIDTH + 2;
  localparam int PW  = 2 * WIDTH;

  typedef struct packed {
    logic [NPP-1:0][PPW-1:0] pp;
    logic                    sgn;
    logic [TAG_W-1:0]        tag;
  } s1_t;

  typedef struct packed {
    logic [PW-1:0]    sum;
    logic [PW-1:0]    carry;
    logic             sgn;
    logic [TAG_W-1:0] tag;
  } s2_t;

  // Wallace-style reduction: each level turns every full group of three rows into sum/carry, passing leftovers through.
  function automatic logic [2*PW-1:0] csa_tree(input logic [NPP-1:0][PPW-1:0] pp);
    logic [PW-1:0] row [NPP];
    logic [PW-1:0] nxt [NPP];
    int n;
    int m;
    for (int i = 0; i < NPP; i++)
      row[i] = {{(PW-PPW){pp[i][PPW-1]}}, pp[i]} << (2 * i);
    n = NPP;
    for (int lvl = 0; lvl < NPP; lvl++) begin
      if (n > 2) begin
        m = 0;
        for (int j = 0; j < NPP; j++) nxt[j] = '0;
        for (int j = 0; j + 2 < NPP; j += 3) begin
          if (j + 2 < n) begin
            nxt[m]   = row[j] ^ row[j+1] ^ row[j+2];
            nxt[m+1] = ((row[j] & row[j+1]) | (row[j] & row[j+2]) | (row[j+1] & row[j+2])) << 1;
            m += 2;
          end
        end
        for (int j = 0; j < NPP; j++) begin
          if (j >= n - n % 3 && j < n) begin
            nxt[m] = row[j];
            m += 1;
          end
        end
        row = nxt;
        n   = m;
      end
    end
    return {row[0], row[1]};
  endfunction

  // Kogge-Stone carry lookahead; carry out of the top bit is dropped.
  function automatic logic [PW-1:0] cla_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW-1:0] p0;
    logic [PW-1:0] gg;
    logic [PW-1:0] pp;
    logic [PW-1:0] gn;
    p0 = x ^ y;
    gg = x & y;
    pp = p0;
    for (int d = 1; d < PW; d = d * 2) begin
      gn = gg | (pp & (gg << d));
      pp = pp & ((pp << d) | ~({PW{1'b1}} << d));
      gg = gn;
    end
    return p0 ^ {gg[PW-2:0], 1'b0};
  endfunction

  logic           v1, v2, v3;
  logic           adv1, adv2, adv3;
  s1_t            s1_d, s1_q;
  s2_t            s2_d, s2_q;
  logic [PPW-1:0] a_ext;
  logic [PPW:0]   b_win;
  logic [PW-1:0]  prod_d;
  logic [WIDTH-1:0] res_d;
  logic           ovf_d;

  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  // Two extension bits let the top Booth digit absorb the unsigned MSB.
  always_comb begin
    a_ext    = {{2{in_signed & in_multiplicand[WIDTH-1]}}, in_multiplicand};
    b_win    = {{2{in_signed & in_multiplier[WIDTH-1]}}, in_multiplier, 1'b0};
    s1_d     = '0;
    s1_d.sgn = in_signed;
    s1_d.tag = in_tag;
    for (int i = 0; i < NPP; i++) begin
      unique case (b_win[2*i +: 3])
        3'b001, 3'b010: s1_d.pp[i] = a_ext;
        3'b011:         s1_d.pp[i] = a_ext << 1;
        3'b100:         s1_d.pp[i] = -(a_ext << 1);
        3'b101, 3'b110: s1_d.pp[i] = -a_ext;
        default:        s1_d.pp[i] = '0;
      endcase
    end
  end

  always_comb begin
    s2_d.sgn = s1_q.sgn;
    s2_d.tag = s1_q.tag;
    {s2_d.sum, s2_d.carry} = csa_tree(s1_q.pp);
  end

  always_comb begin
    prod_d = cla_add(s2_q.sum, s2_q.carry);
    if (s2_q.sgn) begin
      res_d = {prod_d[PW-1], prod_d[WIDTH-2:0]};
      ovf_d = !((&prod_d[PW-1:WIDTH-1]) || !(|prod_d[PW-1:WIDTH-1]));
    end else begin
      res_d = prod_d[WIDTH-1:0];
      ovf_d = |prod_d[PW-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      v3           <= 1'b0;
      s1_q         <= '0;
      s2_q         <= '0;
      out_product  <= '0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_tag      <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) s2_q <= s2_d;
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          out_product  <= prod_d;
          out_result   <= res_d;
          out_overflow <= ovf_d;
          out_tag      <= s2_q.tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_booth_multiplier.sv
// Bench for pipelined_booth_multiplier: directed corner products, streaming, stall, reset and randomized
// traffic on a 32-bit and an 8-bit instance, checked against an arithmetic reference model.
module tb_pipelined_booth_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_overflow;
  logic [31:0] in_multiplicand, in_multiplier, out_result;
  logic [63:0] out_product;
  logic [3:0]  in_tag, out_tag;
  logic        w8_in_valid, w8_in_ready, w8_in_signed, w8_out_valid, w8_out_ready, w8_out_overflow;
  logic [7:0]  w8_a, w8_b, w8_result;
  logic [15:0] w8_product;
  logic [3:0]  w8_in_tag, w8_out_tag;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] p;
    logic [31:0] r;
    logic        o;
    logic [3:0]  t;
  } exp_t;

  always #5 clk = ~clk;

  pipelined_booth_multiplier #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_multiplicand(in_multiplicand), .in_multiplier(in_multiplier),
    .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_result(out_result),
    .out_overflow(out_overflow), .out_tag(out_tag)
  );

  pipelined_booth_multiplier #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .in_multiplicand(w8_a), .in_multiplier(w8_b),
    .in_signed(w8_in_signed), .in_tag(w8_in_tag),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready),
    .out_product(w8_product), .out_result(w8_result),
    .out_overflow(w8_out_overflow), .out_tag(w8_out_tag)
  );

  // Mathematical product of w-bit operands, then the truncation/overflow rules applied to the integer value.
  task automatic ref_model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [63:0] p, output logic [31:0] r, output logic o);
    longint      sa, sb, ps, lim;
    logic [63:0] ua, ub, wmask, pmask;
    wmask = (64'd1 << w) - 64'd1;
    pmask = (w == 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
    ua = {32'd0, a} & wmask;
    ub = {32'd0, b} & wmask;
    if (s) begin
      sa  = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
      sb  = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
      ps  = sa * sb;
      lim = longint'(64'd1 << (w - 1));
      o   = (ps < -lim) || (ps >= lim);
      p   = 64'(ps) & pmask;
      r   = 32'(p & wmask);
      r[w-1] = (ps < 0);
    end else begin
      p = ua * ub;
      o = (p >> w) != 64'd0;
      r = 32'(p & wmask);
    end
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return m;
      3:       return 32'd1 << (w - 1);
      4:       return (32'd1 << (w - 1)) - 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  // Single op into an empty pipe; reports cycles from accept edge to out_valid and the captured outputs.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t,
                        output int lat, output logic [63:0] p, output logic [31:0] r,
                        output logic o, output logic [3:0] tg);
    @(negedge clk);
    in_valid = 1'b1; in_multiplicand = a; in_multiplier = b; in_signed = s; in_tag = t;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    p = out_product; r = out_result; o = out_overflow; tg = out_tag;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_product !== 64'd0 || out_result !== 32'd0 ||
        out_overflow !== 1'b0 || out_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b p=%h r=%h o=%b t=%h, want all zero",
               out_valid, out_product, out_result, out_overflow, out_tag);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_corner_products();
    logic [31:0] ta[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] tb[4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
    logic        ts[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [63:0] ep[4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                           64'hFFFF_FFFE_0000_0001, 64'h0000_0000_FFFF_FFFE};
    logic [31:0] er[4] = '{32'hFFFF_FFEB, 32'h0, 32'h1, 32'h7FFF_FFFE};
    logic        eo[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int lat;
    logic [63:0] p;
    logic [31:0] r;
    logic o;
    logic [3:0] tg;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], ts[i], 4'(i + 3), lat, p, r, o, tg);
      n_checks++;
      if (lat !== 3) begin n_fail++; $display("FAIL latency[%0d]: got %0d cycles, want 3", i, lat); end
      n_checks++;
      if (p !== ep[i]) begin n_fail++; $display("FAIL product[%0d]: got %h, want %h", i, p, ep[i]); end
      n_checks++;
      if (r !== er[i]) begin n_fail++; $display("FAIL result[%0d]: got %h, want %h", i, r, er[i]); end
      n_checks++;
      if (o !== eo[i]) begin n_fail++; $display("FAIL overflow[%0d]: got %b, want %b", i, o, eo[i]); end
      n_checks++;
      if (tg !== 4'(i + 3)) begin n_fail++; $display("FAIL tag[%0d]: got %0d, want %0d", i, tg, i + 3); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e[8];
    logic [31:0] a[8];
    logic [31:0] b[8];
    logic s[8];
    for (int i = 0; i < 8; i++) begin
      a[i] = pick(32); b[i] = pick(32); s[i] = 1'($urandom_range(0, 1));
      ref_model(32, a[i], b[i], s[i], e[i].p, e[i].r, e[i].o);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c < 8) begin
        in_valid = 1'b1; in_multiplicand = a[c]; in_multiplier = b[c]; in_signed = s[c]; in_tag = 4'(c);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 8) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c=%0d: got %b, want 1", c, in_ready); end
      end
      n_checks++;
      if (out_valid !== (c >= 3 && c < 11)) begin
        n_fail++;
        $display("FAIL b2b_out_valid c=%0d: got %b, want %b", c, out_valid, (c >= 3 && c < 11));
      end else if (out_valid) begin
        n_checks++;
        if (out_tag !== 4'(c - 3) || out_product !== e[c-3].p || out_result !== e[c-3].r ||
            out_overflow !== e[c-3].o) begin
          n_fail++;
          $display("FAIL b2b_data c=%0d: got t=%0d p=%h r=%h o=%b, want t=%0d p=%h r=%h o=%b",
                   c, out_tag, out_product, out_result, out_overflow, c - 3, e[c-3].p, e[c-3].r, e[c-3].o);
        end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e[6];
    logic [31:0] a[6];
    logic [31:0] b[6];
    logic s[6];
    int idx = 0;
    int got = 0;
    for (int i = 0; i < 6; i++) begin
      a[i] = pick(32); b[i] = pick(32); s[i] = 1'($urandom_range(0, 1));
      ref_model(32, a[i], b[i], s[i], e[i].p, e[i].r, e[i].o);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_multiplicand = a[idx]; in_multiplier = b[idx]; in_signed = s[idx]; in_tag = 4'(idx + 8);
      out_ready = 1'b0;
      #1;
      if (c >= 3) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c=%0d: got %b, want 0", c, in_ready); end
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd8 || out_product !== e[0].p || out_result !== e[0].r) begin
          n_fail++;
          $display("FAIL stall_hold c=%0d: got v=%b t=%0d p=%h r=%h, want v=1 t=8 p=%h r=%h",
                   c, out_valid, out_tag, out_product, out_result, e[0].p, e[0].r);
        end
      end
      if (in_ready) idx++;
    end
    n_checks++;
    if (idx !== 3) begin n_fail++; $display("FAIL stall_occupancy: got %0d accepted, want 3", idx); end
    for (int c = 0; c < 30 && got < 6; c++) begin
      @(negedge clk);
      if (idx < 6) begin
        in_valid = 1'b1; in_multiplicand = a[idx]; in_multiplier = b[idx]; in_signed = s[idx]; in_tag = 4'(idx + 8);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        n_checks++;
        if (out_tag !== 4'(got + 8) || out_product !== e[got].p || out_overflow !== e[got].o) begin
          n_fail++;
          $display("FAIL stall_drain[%0d]: got t=%0d p=%h o=%b, want t=%0d p=%h o=%b",
                   got, out_tag, out_product, out_overflow, got + 8, e[got].p, e[got].o);
        end
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    n_checks++;
    if (got !== 6) begin n_fail++; $display("FAIL stall_drain_count: got %0d results, want 6", got); end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_multiplicand = pick(32); in_multiplier = pick(32); in_signed = 1'b1;
      in_tag = 4'(12 + c);
      out_ready = 1'b0;
    end
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_full: got out_valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
    end
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_product !== 64'd0 || out_result !== 32'd0 ||
        out_overflow !== 1'b0 || out_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL midflight_async_clear: got v=%b p=%h r=%h o=%b t=%h, want all zero",
               out_valid, out_product, out_result, out_overflow, out_tag);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midflight_in_ready: got %b, want 1", in_ready); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midflight_ghosts: got %0d stale results, want 0", seen); end
  endtask

  task automatic test_random(input int nops);
    exp_t q32[$];
    exp_t q8[$];
    exp_t e;
    exp_t x;
    int sent32 = 0, recv32 = 0, sent8 = 0, recv8 = 0;
    logic acc32 = 1'b0, acc8 = 1'b0;
    in_valid = 1'b0; w8_in_valid = 1'b0;
    for (int cyc = 0; cyc < 60000 && !(recv32 == nops && recv8 == nops); cyc++) begin
      @(negedge clk);
      if (acc32) begin in_valid = 1'b0; acc32 = 1'b0; end
      if (!in_valid && sent32 < nops && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_multiplicand = pick(32); in_multiplier = pick(32);
        in_signed = 1'($urandom_range(0, 1)); in_tag = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc8) begin w8_in_valid = 1'b0; acc8 = 1'b0; end
      if (!w8_in_valid && sent8 < nops && $urandom_range(0, 3) != 0) begin
        w8_in_valid = 1'b1; w8_a = 8'(pick(8)); w8_b = 8'(pick(8));
        w8_in_signed = 1'($urandom_range(0, 1)); w8_in_tag = 4'($urandom);
      end
      w8_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        ref_model(32, in_multiplicand, in_multiplier, in_signed, e.p, e.r, e.o);
        e.t = in_tag;
        q32.push_back(e);
        sent32++; acc32 = 1'b1;
      end
      if (w8_in_valid && w8_in_ready) begin
        ref_model(8, {24'd0, w8_a}, {24'd0, w8_b}, w8_in_signed, e.p, e.r, e.o);
        e.t = w8_in_tag;
        q8.push_back(e);
        sent8++; acc8 = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q32.size() == 0) begin
          n_fail++; $display("FAIL rand32_spurious: result t=%0d with nothing outstanding", out_tag);
        end else begin
          x = q32.pop_front();
          if (out_product !== x.p || out_result !== x.r || out_overflow !== x.o || out_tag !== x.t) begin
            n_fail++;
            $display("FAIL rand32[%0d]: got p=%h r=%h o=%b t=%0d, want p=%h r=%h o=%b t=%0d", recv32,
                     out_product, out_result, out_overflow, out_tag, x.p, x.r, x.o, x.t);
          end
        end
        recv32++;
      end
      if (w8_out_valid && w8_out_ready) begin
        n_checks++;
        if (q8.size() == 0) begin
          n_fail++; $display("FAIL rand8_spurious: result t=%0d with nothing outstanding", w8_out_tag);
        end else begin
          x = q8.pop_front();
          if (w8_product !== x.p[15:0] || w8_result !== x.r[7:0] || w8_out_overflow !== x.o ||
              w8_out_tag !== x.t) begin
            n_fail++;
            $display("FAIL rand8[%0d]: got p=%h r=%h o=%b t=%0d, want p=%h r=%h o=%b t=%0d", recv8,
                     w8_product, w8_result, w8_out_overflow, w8_out_tag, x.p[15:0], x.r[7:0], x.o, x.t);
          end
        end
        recv8++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; w8_in_valid = 1'b0;
    n_checks++;
    if (recv32 !== nops || q32.size() != 0) begin
      n_fail++; $display("FAIL rand32_count: got %0d results (%0d pending), want %0d", recv32, q32.size(), nops);
    end
    n_checks++;
    if (recv8 !== nops || q8.size() != 0) begin
      n_fail++; $display("FAIL rand8_count: got %0d results (%0d pending), want %0d", recv8, q8.size(), nops);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached after %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_multiplicand = '0; in_multiplier = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b0;
    w8_in_valid = 1'b0; w8_a = '0; w8_b = '0; w8_in_signed = 1'b0; w8_in_tag = '0; w8_out_ready = 1'b1;
    test_reset();
    test_corner_products();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random(10000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
